// File: rtl/spi_slave_control.sv
// SPI mode-3 slave: synchronized SPI inputs, tx holding/active words, rx bytes packed into a 32-bit word by fill level.
// Define SPI_SLAVE_ECHO_EN to make the underrun fill byte echo the last received byte instead of 0xFF.
module spi_slave_control #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        spi_clk_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe_o,
  input  logic [31:0] tx_data_i,
  input  logic [2:0]  tx_bytes_valid_i,
  input  logic        tx_load_i,
  output logic        tx_ready_o,
  output logic        tx_underrun_o,
  output logic [31:0] rx_data_o,
  output logic [2:0]  rx_bytes_valid_o,
  output logic        rx_byte_strobe_o,
  input  logic        reset_fill_level_i,
  output logic        busy_o
);

  typedef enum logic {ST_IDLE, ST_SELECTED} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_n_s, mosi_s, sclk_rise, sclk_fall;

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_shift_q;
  logic [2:0]  fill_q;
  logic        fill_rst_q;
  logic [31:0] rx_data_q;
  logic [2:0]  rx_valid_q;
  logic        rx_strobe_q;
  logic [31:0] hold_data_q;
  logic [2:0]  hold_n_q;
  logic        tx_ready_q;
  logic [31:0] act_data_q;
  logic [2:0]  act_left_q;
  logic [7:0]  tx_shift_q;
  logic        byte_start_q;
  logic        miso_q, oe_q, busy_q, underrun_q;

  logic [2:0]  tx_n_norm;
  logic [7:0]  rx_byte;
  logic [2:0]  next_fill;
  logic [7:0]  fill_byte;
  logic [7:0]  start_byte;
  logic [2:0]  start_left;
  logic        start_take_hold, start_underrun;

`ifdef SPI_SLAVE_ECHO_EN
  logic [7:0]  last_rx_q;
  assign fill_byte = last_rx_q;
`else
  assign fill_byte = 8'hFF;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      mosi_sync_q <= '1;
      sclk_prev_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    return w[7:0];
      3'd1:    return w[15:8];
      3'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  always_comb begin
    tx_n_norm = (tx_bytes_valid_i == 3'd0 || tx_bytes_valid_i > 3'd4) ? 3'd4 : tx_bytes_valid_i;
    rx_byte   = {rx_shift_q, mosi_s};
    if (fill_rst_q || reset_fill_level_i || fill_q == 3'd4) next_fill = 3'd1;
    else                                                    next_fill = fill_q + 3'd1;
  end

  // Byte source at byte start: remaining active word, else holding register, else fill byte.
  always_comb begin
    start_byte      = fill_byte;
    start_left      = '0;
    start_take_hold = 1'b0;
    start_underrun  = 1'b0;
    if (act_left_q != 3'd0) begin
      start_byte = sel_byte(act_data_q, act_left_q - 3'd1);
      start_left = act_left_q - 3'd1;
    end else if (!tx_ready_q) begin
      start_take_hold = 1'b1;
      start_byte      = sel_byte(hold_data_q, hold_n_q - 3'd1);
      start_left      = hold_n_q - 3'd1;
    end else begin
      start_underrun = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      fill_q       <= '0;
      fill_rst_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= '0;
      rx_strobe_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_n_q     <= '0;
      tx_ready_q   <= 1'b1;
      act_data_q   <= '0;
      act_left_q   <= '0;
      tx_shift_q   <= '1;
      byte_start_q <= 1'b1;
      miso_q       <= 1'b1;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef SPI_SLAVE_ECHO_EN
      last_rx_q    <= 8'hFF;
`endif
    end else begin
      rx_strobe_q <= 1'b0;
      underrun_q  <= 1'b0;
      if (tx_load_i && tx_ready_q) begin
        hold_data_q <= tx_data_i;
        hold_n_q    <= tx_n_norm;
        tx_ready_q  <= 1'b0;
      end
      if (reset_fill_level_i) fill_rst_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b1;
          oe_q   <= 1'b0;
          busy_q <= 1'b0;
          if (!cs_n_s) begin
            state_q      <= ST_SELECTED;
            oe_q         <= 1'b1;
            busy_q       <= 1'b1;
            bit_cnt_q    <= '0;
            byte_start_q <= 1'b1;
          end
        end
        default: begin
          if (cs_n_s) begin
            state_q      <= ST_IDLE;
            miso_q       <= 1'b1;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            bit_cnt_q    <= '0;
            byte_start_q <= 1'b1;
            // A started-but-unfinished byte poisons the active word and the rx packing position.
            if (!byte_start_q) begin
              act_left_q <= '0;
              fill_q     <= '0;
            end
          end else begin
            if (sclk_fall) begin
              if (byte_start_q) begin
                byte_start_q <= 1'b0;
                miso_q       <= start_byte[7];
                tx_shift_q   <= {start_byte[6:0], 1'b0};
                act_left_q   <= start_left;
                underrun_q   <= start_underrun;
                if (start_take_hold) begin
                  act_data_q <= hold_data_q;
                  tx_ready_q <= 1'b1;
                end
              end else begin
                miso_q     <= tx_shift_q[7];
                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
              end
            end
            if (sclk_rise) begin
              rx_shift_q <= {rx_shift_q[5:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                byte_start_q <= 1'b1;
                fill_q       <= next_fill;
                fill_rst_q   <= 1'b0;
                rx_valid_q   <= next_fill;
                rx_strobe_q  <= 1'b1;
`ifdef SPI_SLAVE_ECHO_EN
                last_rx_q    <= rx_byte;
`endif
                case (next_fill)
                  3'd1:    rx_data_q[31:24] <= rx_byte;
                  3'd2:    rx_data_q[23:16] <= rx_byte;
                  3'd3:    rx_data_q[15:8]  <= rx_byte;
                  default: rx_data_q[7:0]   <= rx_byte;
                endcase
              end
            end
          end
        end
      endcase
    end
  end

  assign spi_miso_o       = miso_q;
  assign spi_miso_oe_o    = oe_q;
  assign busy_o           = busy_q;
  assign tx_ready_o       = tx_ready_q;
  assign tx_underrun_o    = underrun_q;
  assign rx_data_o        = rx_data_q;
  assign rx_bytes_valid_o = rx_valid_q;
  assign rx_byte_strobe_o = rx_strobe_q;

endmodule

// File: tb/tb_spi_slave_control.sv
// Bench for spi_slave_control: mode-3 SPI master driver and a byte-queue reference model of tx/rx behaviour.
`timescale 1ns/1ps
module tb_spi_slave_control;
  localparam int HALF = 6;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        spi_clk = 1'b1, spi_cs_n = 1'b1, spi_mosi = 1'b1;
  logic        spi_miso, spi_miso_oe, tx_ready, tx_underrun, rx_strobe, busy;
  logic [31:0] tx_data = '0, rx_data;
  logic [2:0]  tx_bv = '0, rx_bv;
  logic        tx_load = 1'b0, reset_fill = 1'b0;

  int checks = 0, failures = 0;
  int strobe_cnt = 0, underrun_cnt = 0;
  int strobe_fill_q[$];

  spi_slave_control #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .spi_clk_i(spi_clk), .spi_cs_n_i(spi_cs_n),
    .spi_mosi_i(spi_mosi), .spi_miso_o(spi_miso), .spi_miso_oe_o(spi_miso_oe),
    .tx_data_i(tx_data), .tx_bytes_valid_i(tx_bv), .tx_load_i(tx_load),
    .tx_ready_o(tx_ready), .tx_underrun_o(tx_underrun), .rx_data_o(rx_data),
    .rx_bytes_valid_o(rx_bv), .rx_byte_strobe_o(rx_strobe),
    .reset_fill_level_i(reset_fill), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_fill_q.push_back(int'(rx_bv));
    end
    if (tx_underrun === 1'b1) underrun_cnt++;
  end

  // Reference model: tx as a byte queue, rx as a packed word with a fill position.
  logic        m_hold_full;
  logic [31:0] m_hold_word;
  int          m_hold_n;
  logic [7:0]  m_act[$];
  int          m_fill, m_rxvalid, m_strobes = 0, m_underruns = 0;
  logic [31:0] m_rxword;
  bit          m_latch;
  logic [7:0]  m_last_rx;

  function automatic void model_reset();
    m_hold_full = 1'b0; m_act.delete(); m_fill = 0; m_rxword = '0;
    m_rxvalid = 0; m_latch = 1'b0; m_last_rx = 8'hFF;
  endfunction

  function automatic void model_load(input logic [31:0] w, input logic [2:0] v);
    if (!m_hold_full) begin
      m_hold_full = 1'b1;
      m_hold_word = w;
      m_hold_n    = (v == 3'd0 || v > 3'd4) ? 4 : int'(v);
    end
  endfunction

  function automatic logic [7:0] model_byte_start();
    if (m_act.size() == 0 && m_hold_full) begin
      for (int k = m_hold_n - 1; k >= 0; k--) m_act.push_back(m_hold_word[8*k +: 8]);
      m_hold_full = 1'b0;
    end
    if (m_act.size() == 0) begin
      m_underruns++;
`ifdef SPI_SLAVE_ECHO_EN
      return m_last_rx;
`else
      return 8'hFF;
`endif
    end
    return m_act.pop_front();
  endfunction

  function automatic void model_byte_done(input logic [7:0] b);
    m_fill = m_latch ? 1 : (m_fill % 4) + 1;
    m_latch = 1'b0;
    m_rxword[8*(4-m_fill) +: 8] = b;
    m_rxvalid = m_fill;
    m_last_rx = b;
    m_strobes++;
  endfunction

  function automatic void model_abort();
    m_act.delete();
    m_fill = 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b0; spi_mosi = mo[7-i];
      tick(HALF);
      mi = {mi[6:0], spi_miso};
      spi_clk = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic xfer_byte(input logic [7:0] mo, output logic [7:0] mi, output logic [7:0] exp);
    exp = model_byte_start();
    spi_bits(mo, 8, mi);
    model_byte_done(mo);
  endtask

  task automatic cs_start(); spi_cs_n = 1'b0; tick(HALF); endtask
  task automatic cs_end();   spi_cs_n = 1'b1; tick(HALF + 4); endtask

  task automatic load(input logic [31:0] w, input logic [2:0] v);
    tx_data = w; tx_bv = v; tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    tick(1);
    model_load(w, v);
  endtask

  task automatic pulse_fill_reset();
    reset_fill = 1'b1; tick(1); reset_fill = 1'b0; tick(1);
    m_latch = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(3);
    checks++;
    if ({spi_miso, spi_miso_oe, tx_ready, tx_underrun, rx_strobe, busy} !== 6'b101000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=101000", {spi_miso, spi_miso_oe, tx_ready, tx_underrun, rx_strobe, busy});
    end
    checks++;
    if (rx_data !== 32'h0 || rx_bv !== 3'd0) begin
      failures++; $display("FAIL reset_rx got=%h/%0d exp=0/0", rx_data, rx_bv);
    end
    rstn = 1'b1;
    model_reset();
    tick(3);
  endtask

  task automatic test_four_byte();
    logic [7:0] mo_tab[4];
    logic [7:0] mi, exp;
    int s0;
    mo_tab[0] = 8'h11; mo_tab[1] = 8'h22; mo_tab[2] = 8'h33; mo_tab[3] = 8'h44;
    load(32'hA1B2C3D4, 3'd4);
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL load_ready got=%b exp=0", tx_ready); end
    load(32'hDEADBEEF, 3'd2);
    s0 = strobe_cnt;
    strobe_fill_q.delete();
    cs_start();
    checks++;
    if ({busy, spi_miso_oe} !== 2'b11) begin failures++; $display("FAIL sel_busy_oe got=%b exp=11", {busy, spi_miso_oe}); end
    for (int i = 0; i < 4; i++) begin
      xfer_byte(mo_tab[i], mi, exp);
      checks++;
      if (mi !== exp) begin failures++; $display("FAIL four_miso%0d got=%h exp=%h", i, mi, exp); end
    end
    cs_end();
    checks++;
    if (rx_data !== 32'h11223344) begin failures++; $display("FAIL four_rxdata got=%h exp=11223344", rx_data); end
    checks++;
    if (strobe_cnt - s0 !== 4 || strobe_fill_q.size() != 4) begin
      failures++; $display("FAIL four_strobes got=%0d exp=4", strobe_cnt - s0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (strobe_fill_q[k] !== k + 1) begin failures++; $display("FAIL four_fill%0d got=%0d exp=%0d", k, strobe_fill_q[k], k + 1); end
      end
    end
    checks++;
    if ({busy, spi_miso_oe, spi_miso} !== 3'b001) begin failures++; $display("FAIL idle_outs got=%b exp=001", {busy, spi_miso_oe, spi_miso}); end
  endtask

  task automatic test_underrun();
    logic [7:0] mi, exp;
    int u0;
    u0 = underrun_cnt;
    load(32'h000000AB, 3'd1);
    cs_start();
    xfer_byte(8'h01, mi, exp);
    checks++;
    if (mi !== 8'hAB) begin failures++; $display("FAIL und_first got=%h exp=ab", mi); end
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL und_ready got=%b exp=1", tx_ready); end
    xfer_byte(8'h02, mi, exp);
    checks++;
    if (mi !== exp) begin failures++; $display("FAIL und_fill got=%h exp=%h", mi, exp); end
`ifndef SPI_SLAVE_ECHO_EN
    checks++;
    if (mi !== 8'hFF) begin failures++; $display("FAIL und_ff got=%h exp=ff", mi); end
`endif
    cs_end();
    checks++;
    if (underrun_cnt - u0 !== 1) begin failures++; $display("FAIL und_pulses got=%0d exp=1", underrun_cnt - u0); end
  endtask

  task automatic test_abort();
    logic [7:0] mi, exp, top;
    int s0;
    pulse_fill_reset();
    s0 = strobe_cnt;
    cs_start();
    xfer_byte(8'h6D, mi, exp);
    void'(model_byte_start());
    spi_bits(8'h77, 5, mi);
    cs_end();
    model_abort();
    checks++;
    if (rx_bv !== 3'd1) begin failures++; $display("FAIL abort_valid got=%0d exp=1", rx_bv); end
    checks++;
    if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL abort_strobes got=%0d exp=1", strobe_cnt - s0); end
    checks++;
    if (rx_data !== m_rxword) begin failures++; $display("FAIL abort_rxdata got=%h exp=%h", rx_data, m_rxword); end
    cs_start();
    xfer_byte(8'hC5, mi, exp);
    cs_end();
    top = rx_data[31:24];
    checks++;
    if (top !== 8'hC5 || rx_bv !== 3'd1) begin failures++; $display("FAIL abort_next got=%h/%0d exp=c5/1", top, rx_bv); end
  endtask

  task automatic test_reset_fill();
    logic [7:0] mi, exp, top;
    load(32'h01020304, 3'd0);
    cs_start();
    xfer_byte(8'h31, mi, exp);
    checks++;
    if (mi !== 8'h01) begin failures++; $display("FAIL rf_miso0 got=%h exp=01", mi); end
    xfer_byte(8'h32, mi, exp);
    checks++;
    if (mi !== 8'h02) begin failures++; $display("FAIL rf_miso1 got=%h exp=02", mi); end
    pulse_fill_reset();
    xfer_byte(8'h33, mi, exp);
    cs_end();
    top = rx_data[31:24];
    checks++;
    if (top !== 8'h33 || rx_bv !== 3'd1) begin failures++; $display("FAIL rf_byte3 got=%h/%0d exp=33/1", top, rx_bv); end
    checks++;
    if (rx_data !== m_rxword) begin failures++; $display("FAIL rf_rxdata got=%h exp=%h", rx_data, m_rxword); end
  endtask

`ifdef SPI_SLAVE_ECHO_EN
  task automatic test_echo();
    logic [7:0] mi, exp;
    rstn = 1'b0; tick(2); rstn = 1'b1; model_reset(); tick(2);
    cs_start();
    xfer_byte(8'h5A, mi, exp);
    checks++;
    if (mi !== 8'hFF) begin failures++; $display("FAIL echo_first got=%h exp=ff", mi); end
    xfer_byte(8'h5A, mi, exp);
    checks++;
    if (mi !== 8'h5A) begin failures++; $display("FAIL echo_second got=%h exp=5a", mi); end
    cs_end();
  endtask
`endif

  task automatic test_reset_midbyte();
    logic [7:0] mi, exp;
    load(32'hCAFEF00D, 3'd4);
    cs_start();
    void'(model_byte_start());
    spi_bits(8'h3C, 3, mi);
    rstn = 1'b0;
    #1;
    checks++;
    if ({spi_miso, spi_miso_oe, tx_ready, tx_underrun, rx_strobe, busy} !== 6'b101000 || rx_data !== 32'h0 || rx_bv !== 3'd0) begin
      failures++;
      $display("FAIL rst_mid got=%b/%h/%0d exp=101000/0/0", {spi_miso, spi_miso_oe, tx_ready, tx_underrun, rx_strobe, busy}, rx_data, rx_bv);
    end
    spi_cs_n = 1'b1; spi_clk = 1'b1; spi_mosi = 1'b1;
    tick(2);
    rstn = 1'b1;
    model_reset();
    tick(2);
    load(32'h00C0FFEE, 3'd3);
    cs_start();
    for (int i = 0; i < 3; i++) begin
      xfer_byte(8'h90 + 8'(i), mi, exp);
      checks++;
      if (mi !== exp) begin failures++; $display("FAIL rst_after%0d got=%h exp=%h", i, mi, exp); end
    end
    cs_end();
    checks++;
    if (rx_data !== 32'h90919200 || rx_bv !== 3'd3) begin failures++; $display("FAIL rst_after_rx got=%h/%0d exp=90919200/3", rx_data, rx_bv); end
  endtask

  task automatic test_random();
    logic [7:0] mi, exp, mo;
    int nb;
    bit abort;
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        checks++;
        if (tx_ready !== !m_hold_full) begin failures++; $display("FAIL rnd_ready t=%0d got=%b exp=%b", t, tx_ready, !m_hold_full); end
        load($urandom, 3'($urandom_range(0, 7)));
      end
      nb = $urandom_range(1, 5);
      abort = ($urandom_range(0, 3) == 0);
      cs_start();
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 5) == 0) pulse_fill_reset();
        mo = 8'($urandom);
        if (abort && b == nb - 1) begin
          void'(model_byte_start());
          spi_bits(mo, $urandom_range(1, 7), mi);
        end else begin
          xfer_byte(mo, mi, exp);
          checks++;
          if (mi !== exp) begin failures++; $display("FAIL rnd_miso t=%0d b=%0d got=%h exp=%h", t, b, mi, exp); end
          checks++;
          if (rx_data !== m_rxword || rx_bv !== 3'(m_rxvalid)) begin
            failures++; $display("FAIL rnd_rx t=%0d b=%0d got=%h/%0d exp=%h/%0d", t, b, rx_data, rx_bv, m_rxword, m_rxvalid);
          end
        end
      end
      cs_end();
      if (abort) model_abort();
      checks++;
      if (strobe_cnt !== m_strobes || underrun_cnt !== m_underruns) begin
        failures++; $display("FAIL rnd_counts t=%0d got=%0d/%0d exp=%0d/%0d", t, strobe_cnt, underrun_cnt, m_strobes, m_underruns);
      end
    end
  endtask

  initial begin
    test_reset();
    test_four_byte();
    test_underrun();
    test_abort();
    test_reset_fill();
`ifdef SPI_SLAVE_ECHO_EN
    test_echo();
`endif
    test_reset_midbyte();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
